// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: ACT -> RD/WR -> PRE command sequencer gated by saturating timing counters.
// Closed-page by default; define OPEN_PAGE_EN to leave rows open and track the open row.
module dram_cmd_sequencer #(
  parameter int tRC        = 115,
  parameter int tRAS       = 76,
  parameter int tRP        = 39,
  parameter int tRCD       = 39,
  parameter int tRTP       = 18,
  parameter int tCWD       = 38,
  parameter int tBURST     = 8,
  parameter int tWR        = 30,
  parameter int tCCD_L     = 12,
  parameter int tCCD_L_WR  = 48,
  parameter int tCCD_L_WTR = 70,
  parameter int tCCD_L_RTW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [2:0]  req_bg,
  input  logic [1:0]  req_bank,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        busy
);
  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int WR_PRE = tCWD + tBURST + tWR;
  localparam int TMAX = mx(mx(mx(tRC, tRAS), mx(tRP, tRCD)), mx(mx(tRTP, WR_PRE),
                        mx(mx(tCCD_L, tCCD_L_WR), mx(tCCD_L_WTR, tCCD_L_RTW))));
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE_ACT = 2'd1, ISSUE_COL = 2'd2, ISSUE_PRE = 2'd3;
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_PRE = 3'd4;
  function automatic logic [TW-1:0] ld(input logic [TW-1:0] cur, input int v);
    return cur > TW'(v) ? cur : TW'(v);
  endfunction
  function automatic logic [TW-1:0] dec(input logic [TW-1:0] cur);
    return cur != '0 ? cur - TW'(1) : '0;
  endfunction
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] act_tmr_q, act_tmr_d, col_tmr_q, col_tmr_d, pre_tmr_q, pre_tmr_d;
  logic          op_q, op_d;
  logic [2:0]    bg_q, bg_d;
  logic [1:0]    bank_q, bank_d;
  logic [15:0]   row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_code_q, cmd_code_d, cmd_bg_q, cmd_bg_d;
  logic [1:0]    cmd_bank_q, cmd_bank_d;
  logic [15:0]   cmd_row_q, cmd_row_d;
  logic [9:0]    cmd_col_q, cmd_col_d;
`ifdef OPEN_PAGE_EN
  // x_tmr gates a column command of the opposite type to the previous one
  logic [TW-1:0] x_tmr_q, x_tmr_d;
  logic          last_op_q, last_op_d, open_q, open_d;
  logic [2:0]    open_bg_q, open_bg_d;
  logic [1:0]    open_bank_q, open_bank_d;
  logic [15:0]   open_row_q, open_row_d;
  logic          hit;
`endif
  always_comb begin
    state_d = state_q;
    act_tmr_d = dec(act_tmr_q);
    col_tmr_d = dec(col_tmr_q);
    pre_tmr_d = dec(pre_tmr_q);
    {op_d, bg_d, bank_d, row_d, col_d} = {op_q, bg_q, bank_q, row_q, col_q};
    {cmd_code_d, cmd_bg_d, cmd_bank_d, cmd_row_d, cmd_col_d} = '0;
`ifdef OPEN_PAGE_EN
    x_tmr_d = dec(x_tmr_q);
    last_op_d = last_op_q;
    {open_d, open_bg_d, open_bank_d, open_row_d} = {open_q, open_bg_q, open_bank_q, open_row_q};
    hit = open_q && open_bg_q == req_bg && open_bank_q == req_bank && open_row_q == req_row;
`endif
    unique case (state_q)
      IDLE: if (req_valid) begin
        {op_d, bg_d, bank_d, row_d, col_d} = {req_op, req_bg, req_bank, req_row, req_col};
`ifdef OPEN_PAGE_EN
        state_d = hit ? ISSUE_COL : open_q ? ISSUE_PRE : ISSUE_ACT;
`else
        state_d = ISSUE_ACT;
`endif
      end
      ISSUE_ACT: if (act_tmr_q == '0) begin
        {cmd_code_d, cmd_bg_d, cmd_bank_d, cmd_row_d} = {C_ACT, bg_q, bank_q, row_q};
        act_tmr_d = ld(act_tmr_d, tRC - 1);
        col_tmr_d = ld(col_tmr_d, tRCD - 1);
        pre_tmr_d = ld(pre_tmr_d, tRAS - 1);
        state_d = ISSUE_COL;
`ifdef OPEN_PAGE_EN
        x_tmr_d = ld(x_tmr_d, tRCD - 1);
        {open_d, open_bg_d, open_bank_d, open_row_d} = {1'b1, bg_q, bank_q, row_q};
`endif
      end
`ifdef OPEN_PAGE_EN
      ISSUE_COL: if ((op_q == last_op_q ? col_tmr_q : x_tmr_q) == '0) begin
`else
      ISSUE_COL: if (col_tmr_q == '0) begin
`endif
        {cmd_code_d, cmd_bg_d, cmd_bank_d, cmd_col_d} = {C_RD + {2'b0, op_q}, bg_q, bank_q, col_q};
        pre_tmr_d = ld(pre_tmr_d, op_q ? WR_PRE - 1 : tRTP - 1);
`ifdef OPEN_PAGE_EN
        col_tmr_d = ld(col_tmr_d, op_q ? tCCD_L_WR - 1 : tCCD_L - 1);
        x_tmr_d = ld(x_tmr_d, op_q ? tCCD_L_WTR - 1 : tCCD_L_RTW - 1);
        last_op_d = op_q;
        state_d = IDLE;
`else
        state_d = ISSUE_PRE;
`endif
      end
      default: if (pre_tmr_q == '0) begin
        {cmd_code_d, cmd_bg_d, cmd_bank_d} = {C_PRE, bg_q, bank_q};
        act_tmr_d = ld(act_tmr_d, tRP - 1);
`ifdef OPEN_PAGE_EN
        open_d = 1'b0;
        state_d = ISSUE_ACT;
`else
        state_d = IDLE;
`endif
      end
    endcase
    cmd_valid_d = cmd_code_d != C_NOP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {act_tmr_q, col_tmr_q, pre_tmr_q} <= '0;
      {op_q, bg_q, bank_q, row_q, col_q} <= '0;
      {cmd_valid_q, cmd_code_q, cmd_bg_q, cmd_bank_q, cmd_row_q, cmd_col_q} <= '0;
`ifdef OPEN_PAGE_EN
      {x_tmr_q, last_op_q, open_q, open_bg_q, open_bank_q, open_row_q} <= '0;
`endif
    end else begin
      state_q <= state_d;
      {act_tmr_q, col_tmr_q, pre_tmr_q} <= {act_tmr_d, col_tmr_d, pre_tmr_d};
      {op_q, bg_q, bank_q, row_q, col_q} <= {op_d, bg_d, bank_d, row_d, col_d};
      {cmd_valid_q, cmd_code_q, cmd_bg_q, cmd_bank_q, cmd_row_q, cmd_col_q} <=
        {cmd_valid_d, cmd_code_d, cmd_bg_d, cmd_bank_d, cmd_row_d, cmd_col_d};
`ifdef OPEN_PAGE_EN
      {x_tmr_q, last_op_q, open_q, open_bg_q, open_bank_q, open_row_q} <=
        {x_tmr_d, last_op_d, open_d, open_bg_d, open_bank_d, open_row_d};
`endif
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign {cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col} =
    {cmd_valid_q, cmd_code_q, cmd_bg_q, cmd_bank_q, cmd_row_q, cmd_col_q};
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb_dram_cmd_sequencer: closed-page sequencer bench; directed scenarios plus a randomized
// request stream checked against a timestamp model of the ACT/RD/WR/PRE timing rules.
module tb_dram_cmd_sequencer;
  localparam int tRC = 115, tRAS = 76, tRP = 39, tRCD = 39, tRTP = 18;
  localparam int tCWD = 38, tBURST = 8, tWR = 30;
  logic clk = 0, rst_n = 0, req_valid = 0, req_op = 0;
  logic [2:0] req_bg = 0;
  logic [1:0] req_bank = 0;
  logic [15:0] req_row = 0;
  logic [9:0] req_col = 0;
  logic req_ready, cmd_valid, busy;
  logic [2:0] cmd_code, cmd_bg;
  logic [1:0] cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0] cmd_col;
  dram_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int t;
    logic [2:0] code;
    logic [2:0] bg;
    logic [1:0] bank;
    logic [15:0] row;
    logic [9:0] col;
  } cmd_t;
  int cyc = 0;
  int checks = 0, errors = 0, bad_strobe = 0;
  cmd_t cq[$];
  always @(posedge clk) cyc <= cyc + 1;
  // cyc at a falling edge is the index of the rising edge that registered the outputs
  always @(negedge clk) begin
    cmd_t c;
    if (cmd_valid || cmd_code != 3'd0) begin
      c.t = cyc; c.code = cmd_code; c.bg = cmd_bg; c.bank = cmd_bank; c.row = cmd_row; c.col = cmd_col;
      cq.push_back(c);
    end
    if (cmd_valid != (cmd_code != 3'd0)) bad_strobe++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    tick(2);
    rst_n = 1;
    cq.delete();
  endtask
  task automatic send(input logic op, input logic [2:0] bg, input logic [1:0] bank,
                      input logic [15:0] row, input logic [9:0] col, output int acc, output int pres);
    int n = 0;
    {req_op, req_bg, req_bank, req_row, req_col} = {op, bg, bank, row, col};
    req_valid = 1;
    pres = cyc + 1;
    while (!req_ready && n < 400) begin
      tick(1);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      acc = -1;
      $display("FAIL accept_timeout ready=%b want 1 within 400 cycles", req_ready);
    end else acc = cyc + 1;
    tick(1);
    req_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (busy && n < 1000) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout busy=%b want 0", busy);
    end
    tick(2);
  endtask
  task automatic test_reset();
    int acc, pres;
    do_reset();
    send(1'b1, 3'd5, 2'd2, 16'hBEEF, 10'h155, acc, pres);
    tick(39);
    rst_n = 0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_cmd valid=%b code=%0d want 0 0", cmd_valid, cmd_code);
    end
    checks++;
    if ({cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
      errors++;
      $display("FAIL reset_addr got bg=%0d bank=%0d row=%h col=%h want all 0", cmd_bg, cmd_bank, cmd_row, cmd_col);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake busy=%b ready=%b want 0 1", busy, req_ready);
    end
    tick(2);
    rst_n = 1;
    tick(1);
  endtask
  task automatic test_closed_page(input logic op);
    int acc, pres;
    int et[3];
    logic [2:0] ec[3];
    logic [2:0] bg;
    logic [1:0] bank;
    logic [15:0] row;
    logic [9:0] col;
    bg = 3'($urandom); bank = 2'($urandom); row = 16'($urandom); col = 10'($urandom);
    do_reset();
    send(op, bg, bank, row, col, acc, pres);
    drain();
    et = '{1, 40, op ? 116 : 77};
    ec = '{3'd1, op ? 3'd3 : 3'd2, 3'd4};
    checks++;
    if (cq.size() != 3) begin
      errors++;
      $display("FAIL single_op%0b_count got %0d want 3", op, cq.size());
    end
    for (int i = 0; i < 3 && i < cq.size(); i++) begin
      checks++;
      if (cq[i].t - acc !== et[i] || cq[i].code !== ec[i]) begin
        errors++;
        $display("FAIL single_op%0b_cmd%0d got code=%0d at +%0d want code=%0d at +%0d",
                 op, i, cq[i].code, cq[i].t - acc, ec[i], et[i]);
      end
      checks++;
      if (cq[i].bg !== bg || cq[i].bank !== bank || cq[i].row !== (i == 0 ? row : 16'd0) ||
          cq[i].col !== (i == 1 ? col : 10'd0)) begin
        errors++;
        $display("FAIL single_op%0b_addr%0d got %0d/%0d/%h/%h want %0d/%0d/%h/%h", op, i,
                 cq[i].bg, cq[i].bank, cq[i].row, cq[i].col, bg, bank,
                 i == 0 ? row : 16'd0, i == 1 ? col : 10'd0);
      end
    end
  endtask
  task automatic test_back_to_back();
    int a0, a1, p;
    do_reset();
    send(1'b0, 3'd1, 2'd1, 16'h0101, 10'h011, a0, p);
    send(1'b0, 3'd2, 2'd3, 16'h0202, 10'h022, a1, p);
    drain();
    checks++;
    if (a1 - a0 !== 78) begin
      errors++;
      $display("FAIL b2b_accept got +%0d want +78", a1 - a0);
    end
    checks++;
    if (cq.size() != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", cq.size());
    end else begin
      checks++;
      if (cq[2].code !== 3'd4 || cq[2].t - a0 !== 77 || cq[3].code !== 3'd1 || cq[3].t - a0 !== 116) begin
        errors++;
        $display("FAIL b2b_act2 got PRE %0d@+%0d ACT %0d@+%0d want 4@+77 1@+116",
                 cq[2].code, cq[2].t - a0, cq[3].code, cq[3].t - a0);
      end
    end
  endtask
  task automatic test_reset_mid();
    int acc, pres, rel;
    do_reset();
    send(1'b0, 3'd3, 2'd0, 16'h1234, 10'h0AB, acc, pres);
    while (cyc < acc + 20) tick(1);
    rst_n = 0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_out valid=%b code=%0d busy=%b ready=%b want 0 0 0 1",
               cmd_valid, cmd_code, busy, req_ready);
    end
    tick(3);
    rst_n = 1;
    rel = cyc;
    checks++;
    if (cq.size() != 1 || cq[0].code !== 3'd1) begin
      errors++;
      $display("FAIL midreset_abort got %0d cmds want only the ACT", cq.size());
    end
    cq.delete();
    send(1'b0, 3'd4, 2'd1, 16'h4321, 10'h0CD, acc, pres);
    checks++;
    if (acc !== rel + 1) begin
      errors++;
      $display("FAIL midreset_accept got edge %0d want %0d", acc, rel + 1);
    end
    drain();
    checks++;
    if (cq.size() != 3 || cq[0].t - acc !== 1 || cq[1].t - acc !== 40) begin
      errors++;
      $display("FAIL midreset_restart got %0d cmds ACT@+%0d want 3 cmds ACT@+1 RD@+40",
               cq.size(), cq.size() > 0 ? cq[0].t - acc : -1);
    end
  endtask
  task automatic test_random();
    cmd_t exp[$];
    cmd_t e;
    int last_act = -1000, last_pre = -1000;
    int acc, pres, a, c, p, ea;
    logic op;
    logic [2:0] bg;
    logic [1:0] bank;
    logic [15:0] row;
    logic [9:0] col;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      tick($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 160));
      op = 1'($urandom); bg = 3'($urandom); bank = 2'($urandom); row = 16'($urandom); col = 10'($urandom);
      send(op, bg, bank, row, col, acc, pres);
      ea = pres > last_pre + 1 ? pres : last_pre + 1;
      checks++;
      if (acc !== ea) begin
        errors++;
        $display("FAIL rand%0d_accept got %0d want %0d", r, acc, ea);
      end
      a = acc + 1;
      if (last_act + tRC > a) a = last_act + tRC;
      if (last_pre + tRP > a) a = last_pre + tRP;
      c = a + tRCD;
      p = c + (op ? tCWD + tBURST + tWR : tRTP);
      if (a + tRAS > p) p = a + tRAS;
      e.bg = bg; e.bank = bank;
      e.t = a; e.code = 3'd1; e.row = row; e.col = 0; exp.push_back(e);
      e.t = c; e.code = op ? 3'd3 : 3'd2; e.row = 0; e.col = col; exp.push_back(e);
      e.t = p; e.code = 3'd4; e.row = 0; e.col = 0; exp.push_back(e);
      last_act = a;
      last_pre = p;
    end
    drain();
    checks++;
    if (cq.size() != exp.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", cq.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cq.size(); i++) begin
      checks++;
      if (cq[i].t !== exp[i].t || cq[i].code !== exp[i].code || cq[i].bg !== exp[i].bg ||
          cq[i].bank !== exp[i].bank || cq[i].row !== exp[i].row || cq[i].col !== exp[i].col) begin
        errors++;
        $display("FAIL rand_cmd%0d got %0d@%0d %0d/%0d/%h/%h want %0d@%0d %0d/%0d/%h/%h", i,
                 cq[i].code, cq[i].t, cq[i].bg, cq[i].bank, cq[i].row, cq[i].col,
                 exp[i].code, exp[i].t, exp[i].bg, exp[i].bank, exp[i].row, exp[i].col);
      end
    end
    checks++;
    if (bad_strobe != 0) begin
      errors++;
      $display("FAIL strobe_code got %0d cycles with valid/code disagreeing want 0", bad_strobe);
    end
  endtask
  initial begin
    test_reset();
    test_closed_page(1'b0);
    test_closed_page(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
